// File: rtl/lpt_peripheral.sv
// Centronics parallel-port peripheral: strobe/ack/busy handshake into a first-word
// fall-through FIFO. Define LPT_PERIPHERAL_GLITCH_FILTER_EN to add a 3-sample strobe filter.
module lpt_peripheral #(
    parameter int FIFO_DEPTH = 16,
    parameter int ACK_CYCLES = 250
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          lpt_strobe_n,
    input  logic [7:0]                    lpt_data,
    input  logic                          lpt_init_n,
    input  logic                          paper_out,
    input  logic                          online,
    output logic                          lpt_ack_n,
    output logic                          lpt_busy,
    output logic                          lpt_pout,
    output logic                          lpt_sel,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
    localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(ACK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    logic          strobe_s1_r, strobe_s2_r;
    logic          init_s1_r, init_s2_r;
    logic          pout_s1_r, sel_s1_r;
    logic [7:0]    data_s1_r, data_s2_r;
    logic          strobe_level_s, strobe_prev_r, strobe_fall_s;
    state_t        state_r;
    logic [CW-1:0] ack_cnt_r;
    logic [AW:0]   wr_ptr_r, rd_ptr_r, count_r;
    logic [7:0]    mem_r [FIFO_DEPTH];
    logic          full_s, pop_s, push_s, accept_s, drop_s;

    // Two-flop synchronisers for all host/local asynchronous inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_s1_r <= 1'b1;
            strobe_s2_r <= 1'b1;
            init_s1_r   <= 1'b1;
            init_s2_r   <= 1'b1;
            pout_s1_r   <= 1'b0;
            lpt_pout    <= 1'b0;
            sel_s1_r    <= 1'b0;
            lpt_sel     <= 1'b0;
            data_s1_r   <= 8'h00;
            data_s2_r   <= 8'h00;
        end else begin
            strobe_s1_r <= lpt_strobe_n;
            strobe_s2_r <= strobe_s1_r;
            init_s1_r   <= lpt_init_n;
            init_s2_r   <= init_s1_r;
            pout_s1_r   <= paper_out;
            lpt_pout    <= pout_s1_r;
            sel_s1_r    <= online;
            lpt_sel     <= sel_s1_r;
            data_s1_r   <= lpt_data;
            data_s2_r   <= data_s1_r;
        end
    end

`ifdef LPT_PERIPHERAL_GLITCH_FILTER_EN
    logic [1:0] strobe_hist_r;

    // History of the two previous synchronised strobe samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_hist_r <= 2'b11;
        end else begin
            strobe_hist_r <= {strobe_hist_r[0], strobe_s2_r};
        end
    end

    // Level only follows the strobe once three consecutive samples agree
    always_comb begin
        strobe_level_s = strobe_prev_r;
        if ((strobe_hist_r[0] == strobe_s2_r) && (strobe_hist_r[1] == strobe_s2_r)) begin
            strobe_level_s = strobe_s2_r;
        end else begin
            strobe_level_s = strobe_prev_r;
        end
    end
`else
    // Unfiltered strobe level
    always_comb begin
        strobe_level_s = strobe_s2_r;
    end
`endif

    // Previous strobe level for fall detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_prev_r <= 1'b1;
        end else begin
            strobe_prev_r <= strobe_level_s;
        end
    end

    assign strobe_fall_s = strobe_prev_r & ~strobe_level_s;
    assign full_s        = (count_r == DEPTH_C);
    assign rd_valid      = (count_r != {(AW+1){1'b0}});
    assign pop_s         = rd_valid & rd_ready;
    assign push_s        = (state_r == ST_IDLE) & strobe_fall_s & init_s2_r;
    // A full FIFO still takes the byte when the consumer pops in the same cycle
    assign accept_s      = push_s & (~full_s | pop_s);
    assign drop_s        = push_s & full_s & ~pop_s;
    assign rd_data       = mem_r[rd_ptr_r[AW-1:0]];
    assign fifo_level    = count_r;

    // Handshake FSM with registered ack/busy; init overrides everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            lpt_ack_n <= 1'b1;
            lpt_busy  <= 1'b0;
            ack_cnt_r <= {CW{1'b0}};
        end else if (!init_s2_r) begin
            state_r   <= ST_IDLE;
            lpt_ack_n <= 1'b1;
            lpt_busy  <= 1'b1;
            ack_cnt_r <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (strobe_fall_s) begin
                        state_r   <= ST_ACK;
                        lpt_ack_n <= 1'b0;
                        lpt_busy  <= 1'b1;
                        ack_cnt_r <= CNT_LOAD;
                    end else begin
                        lpt_busy  <= full_s;
                    end
                end
                ST_ACK: begin
                    lpt_busy <= 1'b1;
                    if (ack_cnt_r == {CW{1'b0}}) begin
                        lpt_ack_n <= 1'b1;
                        state_r   <= ST_RELEASE;
                    end else begin
                        ack_cnt_r <= ack_cnt_r - CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (strobe_level_s) begin
                        state_r  <= ST_IDLE;
                        lpt_busy <= full_s;
                    end else begin
                        lpt_busy <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    lpt_ack_n <= 1'b1;
                    lpt_busy  <= 1'b1;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; init flushes the buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (!init_s2_r) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (accept_s && !pop_s) begin
                count_r <= count_r + PTR_ONE;
            end else if (pop_s && !accept_s) begin
                count_r <= count_r - PTR_ONE;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= data_s2_r;
        end
    end

    // Sticky overflow; a drop in the clearing cycle wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop_s) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end else begin
            overflow <= overflow;
        end
    end

endmodule

// File: tb/tb_lpt_peripheral.sv
// Self-checking bench for lpt_peripheral: directed host handshakes with random data
// and widths, compared against a queue model of the receive buffer.
module tb_lpt_peripheral;

`ifdef LPT_PERIPHERAL_GLITCH_FILTER_EN
    localparam int ACT = 4;
`else
    localparam int ACT = 2;
`endif
    localparam int DEPTH = 16;
    localparam int ACKC  = 250;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lpt_strobe_n = 1'b1;
    logic [7:0] lpt_data = 8'h00;
    logic       lpt_init_n = 1'b1;
    logic       paper_out = 1'b0;
    logic       online = 1'b0;
    logic       lpt_ack_n, lpt_busy, lpt_pout, lpt_sel;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [4:0] fifo_level;
    logic       overflow;
    logic       overflow_clr = 1'b0;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] q[$];
    logic       ovf = 1'b0;

    lpt_peripheral #(.FIFO_DEPTH(DEPTH), .ACK_CYCLES(ACKC)) dut (
        .clk(clk), .reset(reset), .lpt_strobe_n(lpt_strobe_n), .lpt_data(lpt_data),
        .lpt_init_n(lpt_init_n), .paper_out(paper_out), .online(online),
        .lpt_ack_n(lpt_ack_n), .lpt_busy(lpt_busy), .lpt_pout(lpt_pout), .lpt_sel(lpt_sel),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .fifo_level(fifo_level), .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One host transfer; checks the handshake edge and model state at the action edge
    task automatic send_checked(input logic [7:0] d, input int low_cycles, input bit pop_at_act,
                                input string tag);
        @(posedge clk); #1;
        lpt_data = d;
        lpt_strobe_n = 1'b0;
        repeat (ACT) @(posedge clk);
        @(negedge clk);
        check({tag, "_busy_pre"}, lpt_busy, (q.size() == DEPTH) ? 1 : 0);
        check({tag, "_ackn_pre"}, lpt_ack_n, 1);
        if (pop_at_act) begin
            check({tag, "_head"}, rd_data, q[0]);
            rd_ready = 1'b1;
        end
        @(posedge clk); #1;
        rd_ready = 1'b0;
        if (pop_at_act) void'(q.pop_front());
        if (q.size() < DEPTH) q.push_back(d);
        else ovf = 1'b1;
        @(negedge clk);
        check({tag, "_busy_act"}, lpt_busy, 1);
        check({tag, "_ackn_act"}, lpt_ack_n, 0);
        check({tag, "_level"}, fifo_level, q.size());
        check({tag, "_ovf"}, overflow, ovf);
        repeat (low_cycles - ACT - 1) @(posedge clk);
        #1 lpt_strobe_n = 1'b1;
        repeat (ACKC + 10) @(posedge clk);
        @(negedge clk);
        check({tag, "_ackn_end"}, lpt_ack_n, 1);
    endtask

    // Pop everything, comparing order against the model
    task automatic drain(input string tag, output logic [7:0] last);
        last = 8'h00;
        while (q.size() > 0) begin
            @(negedge clk);
            check({tag, "_valid"}, rd_valid, 1);
            check({tag, "_data"}, rd_data, q[0]);
            check({tag, "_lvl"}, fifo_level, q.size());
            rd_ready = 1'b1;
            @(posedge clk); #1;
            rd_ready = 1'b0;
            last = q.pop_front();
        end
        @(negedge clk);
        check({tag, "_empty"}, rd_valid, 0);
        check({tag, "_lvl0"}, fifo_level, 0);
    endtask

    initial begin
        logic [7:0] last;
        logic [7:0] rb;
        int         ack_low;
        int         sel_bits;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ackn", lpt_ack_n, 1);
        check("rst_busy", lpt_busy, 0);
        check("rst_pout", lpt_pout, 0);
        check("rst_sel", lpt_sel, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (5) @(posedge clk);

        // Status pass-through with two-cycle latency
        sel_bits = $urandom_range(1, 3);
        @(posedge clk); #1;
        paper_out = sel_bits[0];
        online = sel_bits[1];
        @(posedge clk); @(negedge clk);
        check("pout_lat1", lpt_pout, 0);
        check("sel_lat1", lpt_sel, 0);
        @(posedge clk); @(negedge clk);
        check("pout_lat2", lpt_pout, sel_bits[0]);
        check("sel_lat2", lpt_sel, sel_bits[1]);

        // Test 1: single byte, ack pulse width
        @(posedge clk); #1;
        lpt_data = 8'h41;
        lpt_strobe_n = 1'b0;
        ack_low = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            if (k == 49) #1 lpt_strobe_n = 1'b1;
            @(negedge clk);
            if (lpt_ack_n === 1'b0) ack_low++;
        end
        q.push_back(8'h41);
        check("t1_ack_width", ack_low, ACKC);
        check("t1_busy", lpt_busy, 0);
        check("t1_valid", rd_valid, 1);
        check("t1_data", rd_data, 8'h41);
        check("t1_level", fifo_level, 1);
        drain("t1_drain", last);

        // Test 2: fill, overflow, ordered drain, clear
        for (int i = 0; i < DEPTH; i++) send_checked(8'(i), $urandom_range(ACT + 2, 40), 1'b0, "t2");
        @(negedge clk);
        check("t2_full_busy", lpt_busy, 1);
        check("t2_full_level", fifo_level, DEPTH);
        send_checked(8'hFF, 10, 1'b0, "t2_ovf");
        check("t2_ovf_level", fifo_level, DEPTH);
        check("t2_busy_idle", lpt_busy, 1);
        drain("t2_drain", last);
        check("t2_last", last, 8'h0F);
        check("t2_ovf_sticky", overflow, 1);
        @(posedge clk); #1 overflow_clr = 1'b1;
        @(posedge clk); #1 overflow_clr = 1'b0;
        ovf = 1'b0;
        @(negedge clk);
        check("t2_ovf_clr", overflow, 0);

        // Test 3: push into full FIFO with simultaneous pop
        for (int i = 0; i < DEPTH; i++) send_checked(8'($urandom_range(0, 255)), $urandom_range(ACT + 2, 30), 1'b0, "t3_fill");
        send_checked(8'h55, 10, 1'b1, "t3");
        check("t3_level", fifo_level, DEPTH);
        check("t3_ovf", overflow, 0);
        drain("t3_drain", last);
        check("t3_last", last, 8'h55);

        // Test 4: init during ack with buffered bytes
        for (int i = 0; i < 3; i++) send_checked(8'($urandom_range(0, 255)), $urandom_range(ACT + 2, 20), 1'b0, "t4_pre");
        @(posedge clk); #1;
        lpt_data = 8'($urandom_range(0, 255));
        lpt_strobe_n = 1'b0;
        repeat (10) @(posedge clk);
        #1 lpt_strobe_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t4_in_ack", lpt_ack_n, 0);
        check("t4_pre_level", fifo_level, 4);
        @(posedge clk); #1 lpt_init_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        q.delete();
        check("t4_ackn", lpt_ack_n, 1);
        check("t4_level", fifo_level, 0);
        check("t4_valid", rd_valid, 0);
        check("t4_busy", lpt_busy, 1);
        check("t4_ovf", overflow, ovf);
        repeat (7) @(posedge clk);
        #1 lpt_init_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("t4_busy_rel", lpt_busy, 0);
        check("t4_ackn_rel", lpt_ack_n, 1);
        send_checked(8'h7E, 12, 1'b0, "t4_next");
        drain("t4_drain", last);
        check("t4_last", last, 8'h7E);

        // Test 5: strobe held through the end of ack
        rb = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        lpt_data = rb;
        lpt_strobe_n = 1'b0;
        repeat (ACT + 1) @(posedge clk);
        q.push_back(rb);
        repeat (400 - ACT - 1) @(posedge clk);
        @(negedge clk);
        check("t5_ackn", lpt_ack_n, 1);
        check("t5_busy_hold", lpt_busy, 1);
        @(posedge clk); #1 lpt_strobe_n = 1'b1;
        repeat (ACT) @(posedge clk);
        @(negedge clk);
        check("t5_busy_late", lpt_busy, 1);
        @(posedge clk); @(negedge clk);
        check("t5_busy_drop", lpt_busy, 0);
        check("t5_one_byte", fifo_level, 1);
        drain("t5_drain", last);
        check("t5_data", last, rb);

`ifdef LPT_PERIPHERAL_GLITCH_FILTER_EN
        // Test 6: 2-cycle glitch ignored, then a real strobe
        @(posedge clk); #1;
        lpt_data = 8'($urandom_range(0, 255));
        lpt_strobe_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 lpt_strobe_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t6_glitch_ack", lpt_ack_n, 1);
        check("t6_glitch_busy", lpt_busy, 0);
        check("t6_glitch_level", fifo_level, 0);
        send_checked(8'h33, 10, 1'b0, "t6");
        drain("t6_drain", last);
        check("t6_last", last, 8'h33);
`else
        // Test 6: a 1-cycle strobe pulse is accepted without the filter
        rb = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        lpt_data = rb;
        lpt_strobe_n = 1'b0;
        @(posedge clk); #1 lpt_strobe_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("t6_pulse_pre", lpt_busy, 0);
        @(posedge clk); @(negedge clk);
        q.push_back(rb);
        check("t6_pulse_busy", lpt_busy, 1);
        check("t6_pulse_ackn", lpt_ack_n, 0);
        repeat (ACKC + 10) @(posedge clk);
        drain("t6_drain", last);
        check("t6_last", last, rb);
`endif

        // Asynchronous reset in the middle of a handshake
        @(posedge clk); #1;
        paper_out = 1'b1;
        online = 1'b1;
        lpt_data = 8'($urandom_range(0, 255));
        lpt_strobe_n = 1'b0;
        repeat (ACT + 20) @(posedge clk);
        @(negedge clk);
        check("rst2_pre_ack", lpt_ack_n, 0);
        @(posedge clk); #3 reset = 1'b1;
        #1;
        q.delete();
        ovf = 1'b0;
        check("rst2_ackn", lpt_ack_n, 1);
        check("rst2_busy", lpt_busy, 0);
        check("rst2_level", fifo_level, 0);
        check("rst2_valid", rd_valid, 0);
        check("rst2_pout", lpt_pout, 0);
        check("rst2_sel", lpt_sel, 0);
        lpt_strobe_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst2_after_busy", lpt_busy, 0);
        check("rst2_after_level", fifo_level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
